rob_debug_inst_mem_ctrl: RTL and testbench

Initiator-side controller for the single-port 32x128 debug instruction memory macro. It accepts read/write requests on a valid/ready channel and drives the macro's active-low chip-select, write-enable and output-enable pins. It captures registered read data into a response FIFO with credit-based flow control. After every reset it runs a zero-fill sweep, because macro contents are never reset. It sits between the ROB debug-trace logic and the SRAM macro, with the macro's CE pin tied to `clock`.

---
 rtl/rob_debug_mem_pkg.sv | 19 +
 rtl/rob_debug_rsp_fifo.sv | 49 ++++
 rtl/rob_debug_inst_mem_ctrl.sv | 112 +++++++++++
 tb/tb_rob_debug_inst_mem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_debug_mem_pkg.sv
// Shared constants and types for the ROB debug instruction-memory controller.
package rob_debug_mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 32;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rob_debug_rsp_fifo.sv
// Circular response FIFO: registered head, no fall-through, async active-low reset.
module rob_debug_rsp_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 128,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);
  import rob_debug_mem_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rob_debug_inst_mem_ctrl.sv
// Initiator-side controller for the 32x128 debug instruction SRAM macro:
// zero-fill sweep after reset, valid/ready requests, credit-checked read responses.
module rob_debug_inst_mem_ctrl #(
  parameter int ADDR_W    = rob_debug_mem_pkg::ADDR_W,
  parameter int DATA_W    = rob_debug_mem_pkg::DATA_W,
  parameter int DEPTH     = rob_debug_mem_pkg::DEPTH,
  parameter int RSP_DEPTH = 3,
  parameter int INIT_EN   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);
  import rob_debug_mem_pkg::*;

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] i_q;
  logic              rd_inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              credit_ok;
  logic              fire;
  logic              rd_fire;

  assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight})
                     < (CNT_W + 1)'(RSP_DEPTH);
  assign req_ready = (state == RUN) && (req_write || credit_ok);
  assign fire      = req_valid && req_ready;
  assign rd_fire   = fire && !req_write;
  assign rsp_valid = (fifo_count != '0);

  // Macro pins are gated by reset_n so the free-running CE never sees a
  // select while reset is held, and the pins show their idle values.
  assign sram_oeb = !(reset_n && (state == RUN));

  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = a_q;
    sram_i   = i_q;
    if (reset_n) begin
      if (state == INIT) begin
        sram_csb = 1'b0;
        sram_web = 1'b0;
        sram_a   = sweep_cnt;
        sram_i   = '0;
      end else if (fire) begin
        sram_csb = 1'b0;
        sram_web = !req_write;
        sram_a   = req_addr;
        sram_i   = req_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= (INIT_EN != 0) ? INIT : RUN;
      sweep_cnt   <= '0;
      init_done   <= 1'b0;
      rd_inflight <= 1'b0;
      a_q         <= '0;
      i_q         <= '0;
    end else begin
      a_q         <= sram_a;
      i_q         <= sram_i;
      rd_inflight <= rd_fire;
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: init_done <= 1'b1;
      endcase
    end
  end

  rob_debug_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data (sram_o),
    .pop       (rsp_ready),
    .count     (fifo_count),
    .head      (rsp_rdata)
  );

endmodule

// File: tb/tb_rob_debug_inst_mem_ctrl.sv
// Self-checking bench: behavioural SRAM macro, shadow-memory response model, scenario tasks.
module tb_rob_debug_inst_mem_ctrl;
  import rob_debug_mem_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [4:0]   req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_rdata;
  logic         init_done;
  logic         sram_csb;
  logic         sram_web;
  logic         sram_oeb;
  logic [4:0]   sram_a;
  logic [127:0] sram_i;
  logic [127:0] sram_o;

  int n_checks = 0;
  int n_fail   = 0;
  int chk_idx  = 0;

  always #5 clock = ~clock;

  rob_debug_inst_mem_ctrl #(
    .ADDR_W    (5),
    .DATA_W    (128),
    .DEPTH     (32),
    .RSP_DEPTH (3),
    .INIT_EN   (1)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb),
    .sram_a    (sram_a),
    .sram_i    (sram_i),
    .sram_o    (sram_o)
  );

  // Behavioural macro: synchronous write, registered read; starts full of garbage.
  logic [127:0] mem [32];
  logic [127:0] mem_dout = '0;
  req_t         wr_log [$];

  initial for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

  always @(posedge clock) begin
    if (!reset_n) wr_log.delete();
    if (!sram_csb) begin
      if (!sram_web) begin
        mem[sram_a] <= sram_i;
        if (reset_n) wr_log.push_back('{write: 1'b1, addr: sram_a, wdata: sram_i});
      end else begin
        mem_dout <= mem[sram_a];
      end
    end
  end
  assign sram_o = mem_dout;

  // Reference model: memory is all-zero after any reset's sweep; each accepted
  // read expects the latest accepted write to that address, in issue order.
  logic [127:0] shadow [32];
  logic [127:0] exp_q [$];
  logic [127:0] got_q [$];

  always @(negedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) shadow[i] <= '0;
      exp_q.delete();
      got_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        if (req_write) shadow[req_addr] <= req_wdata;
        else           exp_q.push_back(shadow[req_addr]);
      end
      if (rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers (no checking). Called and returning 1 time unit after a rising edge.
  task automatic issue(input logic w, input logic [4:0] a, input logic [127:0] d,
                       output int waits);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    waits     = 0;
    @(negedge clock);
    while (!req_ready && waits < 40) begin
      waits++;
      @(posedge clock); #1;
      @(negedge clock);
    end
    if (!req_ready) req_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic drain(output logic timed_out);
    int quiet = 0;
    int n = 0;
    rsp_ready = 1'b1;
    while (quiet < 3 && n < 100) begin
      @(negedge clock);
      quiet = rsp_valid ? 0 : quiet + 1;
      n++;
      @(posedge clock); #1;
    end
    timed_out = (quiet < 3);
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    n_checks++; if (sram_csb !== 1'b1) begin n_fail++; $display("FAIL rst_csb: got %b want 1", sram_csb); end
    n_checks++; if (sram_web !== 1'b1) begin n_fail++; $display("FAIL rst_web: got %b want 1", sram_web); end
    n_checks++; if (sram_oeb !== 1'b1) begin n_fail++; $display("FAIL rst_oeb: got %b want 1", sram_oeb); end
    n_checks++; if (sram_a !== 5'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", sram_a); end
    n_checks++; if (sram_i !== 128'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", sram_i); end
    @(posedge clock); #1;
  endtask

  // Expects reset held low on entry; releases it and checks the whole sweep.
  task automatic test_sweep();
    int cycles = 0;
    int rdy_seen = 0;
    int waits;
    int bad = 0;
    logic to;
    req_valid = 1'b0;
    req_write = 1'b1;
    reset_n   = 1'b1;
    @(negedge clock);
    n_checks++; if (sram_csb !== 1'b0 || sram_web !== 1'b0 || sram_a !== 5'd0 || sram_oeb !== 1'b1) begin
      n_fail++; $display("FAIL sweep_first: csb=%b web=%b a=%0d oeb=%b want 0 0 0 1", sram_csb, sram_web, sram_a, sram_oeb);
    end
    while (!init_done && cycles < 100) begin
      if (req_ready) rdy_seen++;
      @(posedge clock); #1;
      cycles++;
      @(negedge clock);
    end
    n_checks++; if (cycles != 32) begin n_fail++; $display("FAIL sweep_len: init_done after %0d cycles want 32", cycles); end
    n_checks++; if (rdy_seen != 0) begin n_fail++; $display("FAIL sweep_ready: req_ready high %0d cycles want 0", rdy_seen); end
    n_checks++; if (wr_log.size() != 32) begin n_fail++; $display("FAIL sweep_writes: got %0d writes want 32", wr_log.size()); end
    for (int i = 0; i < wr_log.size() && i < 32; i++)
      if (wr_log[i].addr !== 5'(i) || wr_log[i].wdata !== 128'd0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL sweep_order: %0d bad writes want 0 (addr 0..31, data 0)", bad); end
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    issue(1'b0, 5'd17, '0, waits);
    req_valid = 1'b0;
    drain(to);
    n_checks++; if (to || got_q.size() != chk_idx + 1) begin
      n_fail++; $display("FAIL sweep_read17_count: got %0d responses want %0d", got_q.size() - chk_idx, 1);
    end else begin
      n_checks++; if (got_q[chk_idx] !== 128'd0) begin n_fail++; $display("FAIL sweep_read17: got %h want 0", got_q[chk_idx]); end
    end
    chk_idx = got_q.size();
  endtask

  task automatic test_write_read();
    logic [127:0] v;
    int w1, w2;
    logic to;
    v = 128'hDEADBEEF_00000000_00000000_00000001;
    rsp_ready = 1'b0;
    issue(1'b1, 5'd5, v, w1);
    issue(1'b0, 5'd5, '0, w2);
    req_valid = 1'b0;
    n_checks++; if (w1 != 0 || w2 != 0) begin n_fail++; $display("FAIL wr_rd_accept: waits %0d/%0d want 0/0", w1, w2); end
    @(negedge clock);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_lat1: rsp_valid %b want 0", rsp_valid); end
    n_checks++; if (sram_oeb !== 1'b0) begin n_fail++; $display("FAIL run_oeb: got %b want 0", sram_oeb); end
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_lat2: rsp_valid %b want 1", rsp_valid); end
    n_checks++; if (rsp_rdata !== v) begin n_fail++; $display("FAIL wr_rd_data: got %h want %h", rsp_rdata, v); end
    @(posedge clock); #1;
    drain(to);
    n_checks++; if (to || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wr_rd_count: got %0d responses want %0d", got_q.size(), exp_q.size());
    end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_rd_q[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_back_to_back();
    int waits;
    int rd_waits = 0;
    logic to;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      issue(1'b1, 5'(i), {$urandom, $urandom, $urandom, $urandom}, waits);
      rd_waits += waits;
    end
    for (int i = 0; i < 32; i++) begin
      issue(1'b0, 5'(i), '0, waits);
      rd_waits += waits;
    end
    req_valid = 1'b0;
    n_checks++; if (rd_waits != 0) begin n_fail++; $display("FAIL b2b_ready: %0d stall cycles want 0", rd_waits); end
    drain(to);
    n_checks++; if (to || got_q.size() - chk_idx != 32 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d responses want 32", got_q.size() - chk_idx);
    end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_q[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic to;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'($urandom_range(0, 31));
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (req_ready) acc++;
      @(posedge clock); #1;
      req_addr = 5'($urandom_range(0, 31));
    end
    n_checks++; if (acc != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d reads want 3", acc); end
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_rd_stall: req_ready %b want 0", req_ready); end
    @(posedge clock); #1;
    req_write = 1'b1;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_write: req_ready %b want 1", req_ready); end
    @(posedge clock); #1;
    req_valid = 1'b0;
    drain(to);
    n_checks++; if (to || got_q.size() - chk_idx != 3 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d responses want 3", got_q.size() - chk_idx);
    end
    for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_q[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_mid_reset();
    int w1, w2;
    rsp_ready = 1'b0;
    issue(1'b0, 5'($urandom_range(0, 31)), '0, w1);
    issue(1'b0, 5'($urandom_range(0, 31)), '0, w2);
    req_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: rsp_valid %b want 1", rsp_valid); end
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (sram_csb !== 1'b1) begin n_fail++; $display("FAIL mid_csb: got %b want 1", sram_csb); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done: got %b want 0", init_done); end
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_idx = 0;
    test_sweep();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    test_sweep();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
